// File: rtl/onewire_pkg.sv
// Shared constants and types for the 1-wire master arbiter.
// State encodings are plain constants so older flows can consume them.
package onewire_pkg;

   localparam int DATA_W          = 56;
   localparam int TIMEOUT_CYC_DEF = 20000;
   localparam int GAP_CYC_DEF     = 16;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_RESP  = 3'd3;
   localparam logic [2:0] ST_GAP   = 3'd4;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              error;
      logic              timeout;
   } rsp_t;

endpackage

// File: rtl/onewire_arbiter_if.sv
// Requester and 1-wire master signals of the arbiter.
// The master modport is the arbiter side; slave is the environment side.
interface onewire_arbiter_if #(
   parameter int NUM_REQ = 4
);

   localparam int DW = onewire_pkg::DATA_W;

   logic [NUM_REQ-1:0]    i_req;
   logic [NUM_REQ*DW-1:0] i_req_data;
   logic [NUM_REQ-1:0]    o_gnt;
   logic [NUM_REQ-1:0]    o_done;
   logic [DW-1:0]         o_rsp_data;
   logic                  o_rsp_error;
   logic                  o_rsp_timeout;
   logic                  o_busy;
   logic                  o_tx_start;
   logic [DW-1:0]         o_tx_data;
   logic                  i_tx_done;
   logic [DW-1:0]         i_rx_data;
   logic                  i_rx_error;

   modport master (
      input  i_req, i_req_data,
      input  i_tx_done, i_rx_data, i_rx_error,
      output o_gnt, o_done, o_busy,
      output o_rsp_data, o_rsp_error, o_rsp_timeout,
      output o_tx_start, o_tx_data
   );

   modport slave (
      output i_req, i_req_data,
      output i_tx_done, i_rx_data, i_rx_error,
      input  o_gnt, o_done, o_busy,
      input  o_rsp_data, o_rsp_error, o_rsp_timeout,
      input  o_tx_start, o_tx_data
   );

endinterface

// File: rtl/onewire_arbiter_rr.sv
// Combinational round-robin picker: first request above i_ptr, wrapping.
// Produces a one-hot grant, or all zeros when nothing is requested.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PW-1:0]      i_ptr,
   output logic [NUM_REQ-1:0] o_gnt
);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      o_gnt = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = PW'((int'(i_ptr) + i) % NUM_REQ);
         if (!found && i_req[idx]) begin
            o_gnt[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/onewire_arbiter.sv
// Shares one 1-wire master between NUM_REQ requesters: grant, start,
// wait for done or timeout, return the response, then hold a bus gap.
module onewire_arbiter
   import onewire_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int GAP_CYC     = GAP_CYC_DEF
) (
   input logic               clk,
   input logic               reset,
   onewire_arbiter_if.master bus
);

   localparam int PW      = $clog2(NUM_REQ);
   localparam int CNT_MAX = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
   localparam int CW      = $clog2(CNT_MAX);

   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

   logic [2:0]         state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               tx_start_q, tx_start_d;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;
   rsp_t               rsp_q, rsp_d;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [DATA_W-1:0]  arb_data;
   logic [PW-1:0]      win_idx;
   logic [CW-1:0]      cnt_inc;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_rr (
      .i_req (bus.i_req),
      .i_ptr (ptr_q),
      .o_gnt (arb_gnt)
   );

   always_comb begin
      arb_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (arb_gnt[k]) arb_data = bus.i_req_data[k*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      win_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt_q[k]) win_idx = PW'(k);
      end
   end

   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      gnt_d      = gnt_q;
      done_d     = '0;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      rsp_d      = rsp_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|bus.i_req) begin
               gnt_d      = arb_gnt;
               tx_data_d  = arb_data;
               tx_start_d = 1'b1;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_inc;
            // done takes precedence over a timeout in the same cycle
            if (bus.i_tx_done) begin
               rsp_d.data    = bus.i_rx_data;
               rsp_d.error   = bus.i_rx_error;
               rsp_d.timeout = 1'b0;
               done_d        = gnt_q;
               state_d       = ST_RESP;
            end else if (cnt_inc == TO_LAST) begin
               rsp_d.data    = '0;
               rsp_d.error   = 1'b0;
               rsp_d.timeout = 1'b1;
               done_d        = gnt_q;
               state_d       = ST_RESP;
            end
         end
         ST_RESP: begin
            ptr_d   = win_idx;
            cnt_d   = '0;
            gnt_d   = '0;
            state_d = ST_GAP;
         end
         ST_GAP: begin
            cnt_d = cnt_inc;
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ptr_q      <= PW'(NUM_REQ - 1);
         cnt_q      <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         rsp_q      <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         rsp_q      <= rsp_d;
      end
   end

   assign bus.o_gnt         = gnt_q;
   assign bus.o_done        = done_q;
   assign bus.o_busy        = (state_q != ST_IDLE);
   assign bus.o_tx_start    = tx_start_q;
   assign bus.o_tx_data     = tx_data_q;
   assign bus.o_rsp_data    = rsp_q.data;
   assign bus.o_rsp_error   = rsp_q.error;
   assign bus.o_rsp_timeout = rsp_q.timeout;

endmodule

// File: doc/onewire_arbiter.md
Name: onewire_arbiter

Overview:
Shares one 1-wire master (56-bit frame, CRC checked in the master) between NUM_REQ on-chip requesters. The block sequences each transaction:
- round-robin grant
- tx_start pulse
- wait for done or timeout
- return the response to the winner
- enforce a bus recovery gap

It sits between the requester blocks and the onewire master/slave datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 56, command/response frame width
TIMEOUT_CYC, 20000, max clk cycles from tx_start to i_tx_done
GAP_CYC, 16, idle cycles enforced between transactions

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_req  in  NUM_REQ  per-requester request level
i_req_data  in  NUM_REQ*DATA_W  packed commands; requester k owns bits [k*DATA_W +: DATA_W]
o_gnt  out  NUM_REQ  one-hot grant
o_done  out  NUM_REQ  one-cycle completion pulse to the granted requester
o_rsp_data  out  DATA_W  response frame
o_rsp_error  out  1  master reported error (CRC) for the response
o_rsp_timeout  out  1  transaction timed out
o_busy  out  1  high in any state other than IDLE
o_tx_start  out  1  one-cycle start pulse to master
o_tx_data  out  DATA_W  command to master
i_tx_done  in  1  master completion pulse
i_rx_data  in  DATA_W  master received frame, valid with i_tx_done
i_rx_error  in  1  master error flag, valid with i_tx_done

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; clk and reset are named as in the rest of the codebase.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - RR pointer is NUM_REQ-1, so req0 has highest priority first.
  - Counter is 0.
- States: IDLE, START, WAIT, RESP, GAP.
- IDLE:
  - If any i_req bit is set, the winner is the first set bit searching from pointer+1 upward, with wrap.
  - At the edge: register the one-hot o_gnt, latch the winner's data into o_tx_data, and go to START.
  - Latency: req sampled at edge t produces o_gnt and o_tx_start high in cycle t+1.
- START:
  - o_tx_start = 1 for exactly one cycle.
  - Counter cleared; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On i_tx_done: capture i_rx_data and i_rx_error, set timeout flag = 0, go to RESP.
  - If the counter reaches TIMEOUT_CYC-1 without done: set data = 0, error = 0, timeout = 1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - o_done[winner] = 1 for one cycle.
  - o_rsp_data, o_rsp_error and o_rsp_timeout update at entry to RESP and hold until the next RESP.
  - Pointer is set to the winner index; counter is cleared; go to GAP.
- GAP:
  - o_gnt = 0 and o_busy = 1.
  - Stay GAP_CYC cycles, then go to IDLE.
  - A request pending during GAP is arbitrated in IDLE.
- o_tx_data and o_gnt are held stable from START through RESP.
- Requester rule: hold i_req until o_done; data must be stable while i_req is high.
  - If i_req drops mid-transaction, the transaction still completes and o_done still pulses.
  - A requester keeping i_req high after o_done is re-arbitrated normally and gets lowest priority next round.
- i_tx_done outside WAIT is ignored.
- Only one o_done bit and at most one o_gnt bit are ever set.
- Reset mid-transaction: immediate return to reset values with no o_done pulse; the master must share the same reset.
- Counter width is clog2(max(TIMEOUT_CYC, GAP_CYC)) bits; no wrap is possible.

Decomposition:
- onewire_pkg holds:
  - DATA_W = 56
  - state enum/localparams (IDLE..GAP)
  - default TIMEOUT_CYC and GAP_CYC
- Sub-module rr_arbiter (parameter NUM_REQ): inputs are the req vector and the pointer; output is the one-hot grant (combinational).
  - The pointer register and FSM live in onewire_arbiter.

Test Plan:
- Single request: req0 with data 56'hAA55AA55AA55AA.
  -> o_gnt = 4'b0001 and o_tx_start pulse 1 cycle later.
  -> o_tx_data = AA55AA55AA55AA.
  -> model master asserts done with rx 56'hAA55AA55AA55AA, error 0.
  -> o_done[0] pulse, o_rsp_data matches, o_rsp_error 0, then GAP_CYC idle cycles.
- Round robin: req0..req3 all held high.
  -> grant order 0, 1, 2, 3, 0.
  -> each o_done pulse goes to the matching requester only.
- Timeout: req2 and the master never asserts done.
  -> o_done[2] exactly TIMEOUT_CYC cycles after o_tx_start.
  -> o_rsp_timeout 1, o_rsp_data 0.
- CRC error: master returns done with i_rx_error = 1 and rx 56'hAA55AA55AA55AB.
  -> o_rsp_error 1, o_rsp_timeout 0, data passed through.
- Edge cases:
  - Done coincides with the last timeout cycle -> o_rsp_timeout 0, data captured.
  - Spurious i_tx_done in IDLE -> no o_done.
- Reset during WAIT.
  -> next cycle all outputs 0 and state IDLE.
  -> a pending req1 is then granted before req3 (pointer reset).
